// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU front end:
// opcodes, addressing modes, registers and the decoded bundle.
package cpu_isa_pkg;

  localparam logic [6:0] OP_NOP = 7'd0;
  localparam logic [6:0] OP_ADD = 7'd1;
  localparam logic [6:0] OP_SUB = 7'd2;
  localparam logic [6:0] OP_XOR = 7'd3;
  localparam logic [6:0] OP_AND = 7'd4;
  localparam logic [6:0] OP_OR  = 7'd5;
  localparam logic [6:0] OP_NOT = 7'd6;

  localparam logic [1:0] MOD_RR   = 2'b00;
  localparam logic [1:0] MOD_RI   = 2'b01;
  localparam logic [1:0] MOD_RIND = 2'b10;
  localparam logic [1:0] MOD_RM   = 2'b11;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [2:0] ER0 = 3'd0;
  localparam logic [2:0] ER1 = 3'd1;
  localparam logic [2:0] ER2 = 3'd2;
  localparam logic [2:0] ER3 = 3'd3;
  localparam logic [2:0] SP  = 3'd4;
  localparam logic [2:0] PC  = 3'd5;

  typedef struct packed {
    logic        ext;
    logic [6:0]  opcode;
    logic [1:0]  mod;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic [2:0]  len;
    logic        illegal;
  } dec_instr_t;

  function automatic logic [2:0] instr_len(
    input logic       ext,
    input logic [6:0] opcode,
    input logic [1:0] mod
  );
    logic [2:0] len;
    len = 3'd2;
    if (opcode == OP_NOP) begin
      len = 3'd1;
    end else begin
      unique case (mod)
        MOD_RR:   len = 3'd2;
        MOD_RIND: len = 3'd2;
        MOD_RI:   len = ext ? 3'd4 : 3'd3;
        MOD_RM:   len = 3'd4;
        default:  len = 3'd2;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/instr_len_check.sv
// Length and legality of an instruction from byte0
// fields plus the addressing mode of the modrm byte.
module instr_len_check
  import cpu_isa_pkg::*;
#(
  parameter int OPC_MAX = 6,
  parameter int EXT_EN  = 1
) (
  input  logic       ext_i,
  input  logic [6:0] opcode_i,
  input  logic [1:0] mod_i,
  output logic [2:0] len_o,
  output logic       illegal_o
);

  logic bad_op;
  logic bad_ind;
  logic bad_not;
  logic bad_ext;

  assign bad_op  = int'(opcode_i) > OPC_MAX;
  assign bad_ind = (mod_i == MOD_RIND) && !ext_i;
  assign bad_not = (opcode_i == OP_NOT)
                && (mod_i == MOD_RI);
  assign bad_ext = ext_i && (EXT_EN == 0);

  // An illegal encoding stops after modrm so the
  // consumer can resync from the very next byte.
  always_comb begin
    illegal_o = bad_op | bad_ind | bad_not | bad_ext;
    len_o     = instr_len(ext_i, opcode_i, mod_i);
    if (illegal_o) len_o = 3'd2;
  end

endmodule

// File: rtl/instr_stream_decoder.sv
// Byte-serial decoder assembling 1-4 byte instructions
// into one registered decoded bundle per handshake.
module instr_stream_decoder
  import cpu_isa_pkg::*;
#(
  parameter int OPC_MAX = 6,
  parameter int EXT_EN  = 1,
  parameter int IMM_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ext,
  output logic [6:0]       out_opcode,
  output logic [1:0]       out_mod,
  output logic [2:0]       out_rd,
  output logic [2:0]       out_rs,
  output logic [IMM_W-1:0] out_imm,
  output logic [2:0]       out_len,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    S_OP,
    S_MODRM,
    S_B2,
    S_B3,
    S_HOLD
  } state_e;

  state_e     state_q, state_d;
  dec_instr_t dec_q, dec_d;
  logic       valid_q, valid_d;
  logic [2:0] chk_len;
  logic       chk_ill;
  logic       acc;

  instr_len_check #(
    .OPC_MAX (OPC_MAX),
    .EXT_EN  (EXT_EN)
  ) u_len (
    .ext_i     (dec_q.ext),
    .opcode_i  (dec_q.opcode),
    .mod_i     (in_byte[7:6]),
    .len_o     (chk_len),
    .illegal_o (chk_ill)
  );

  assign in_ready = (state_q != S_HOLD) && !flush;
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = S_OP;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_OP: if (acc) begin
          // fresh bundle: stale modrm/imm never leak
          dec_d        = '0;
          dec_d.ext    = in_byte[7];
          dec_d.opcode = in_byte[6:0];
          if (in_byte[6:0] == OP_NOP) begin
            dec_d.len = 3'd1;
            state_d   = S_HOLD;
            valid_d   = 1'b1;
          end else begin
            state_d = S_MODRM;
          end
        end
        S_MODRM: if (acc) begin
          dec_d.mod     = in_byte[7:6];
          dec_d.rd      = in_byte[5:3];
          dec_d.rs      = in_byte[2:0];
          dec_d.len     = chk_len;
          dec_d.illegal = chk_ill;
          if (chk_len == 3'd2) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = S_B2;
          end
        end
        S_B2: if (acc) begin
          dec_d.imm[7:0] = in_byte;
          if (dec_q.len == 3'd3) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = S_B3;
          end
        end
        S_B3: if (acc) begin
          dec_d.imm[15:8] = in_byte;
          state_d         = S_HOLD;
          valid_d         = 1'b1;
        end
        S_HOLD: if (out_ready) begin
          state_d = S_OP;
          valid_d = 1'b0;
        end
        default: begin
          state_d = S_OP;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP;
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_ext     = dec_q.ext;
  assign out_opcode  = dec_q.opcode;
  assign out_mod     = dec_q.mod;
  assign out_rd      = dec_q.rd;
  assign out_rs      = dec_q.rs;
  assign out_imm     = IMM_W'(dec_q.imm);
  assign out_len     = dec_q.len;
  assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Directed bench for instr_stream_decoder with an
// expected-result queue drained by an output monitor.
module tb_instr_stream_decoder;

  typedef struct packed {
    logic        ext;
    logic [6:0]  op;
    logic [1:0]  mod;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic [2:0]  len;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_ext;
  logic [6:0]  out_opcode;
  logic [1:0]  out_mod;
  logic [2:0]  out_rd;
  logic [2:0]  out_rs;
  logic [15:0] out_imm;
  logic [2:0]  out_len;
  logic        out_illegal;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e_sub;

  always #5 clk = ~clk;

  instr_stream_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ext     (out_ext),
    .out_opcode  (out_opcode),
    .out_mod     (out_mod),
    .out_rd      (out_rd),
    .out_rs      (out_rs),
    .out_imm     (out_imm),
    .out_len     (out_len),
    .out_illegal (out_illegal)
  );

  function automatic exp_t mk(
    input logic        ext,
    input logic [6:0]  op,
    input logic [1:0]  mod,
    input logic [2:0]  rd,
    input logic [2:0]  rs,
    input logic [15:0] imm,
    input logic [2:0]  len,
    input logic        ill
  );
    return {ext, op, mod, rd, rs, imm, len, ill};
  endfunction

  function automatic exp_t get_obs();
    return {out_ext, out_opcode, out_mod, out_rd,
            out_rs, out_imm, out_len, out_illegal};
  endfunction

  task automatic chk_bit(input string tag,
                         input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag,
                         input exp_t obs,
                         input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // pop one expectation per output transfer
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_out obs=%h exp=none",
               get_obs());
      end else begin
        chk_dec("txn", get_obs(), sb.pop_front());
      end
    end
  end

  // starts and ends at posedge+1
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_bit("send_timeout", n < 50, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic valid_next();
    @(negedge clk);
    chk_bit("latency", out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_bit("drain", sb.size() == 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    #12;
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_dec("rst_fields", get_obs(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_bit("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // NOP stream
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h00);
    valid_next();
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h00);
    valid_next();
    drain();

    // ADD R5,R7
    sb.push_back(mk(1'b0, 7'd1, 2'b00, 3'd5, 3'd7,
                    16'h0, 3'd2, 1'b0));
    send(8'h01);
    send(8'h2F);
    valid_next();
    drain();

    // ADD ER1,imm16
    sb.push_back(mk(1'b1, 7'd1, 2'b01, 3'd1, 3'd0,
                    16'hBEEF, 3'd4, 1'b0));
    send(8'h81);
    send(8'h48);
    send(8'hEF);
    send(8'hBE);
    valid_next();
    drain();

    // XOR reg-mem, ext=0 still 4 bytes
    sb.push_back(mk(1'b0, 7'd3, 2'b11, 3'd0, 3'd1,
                    16'h1234, 3'd4, 1'b0));
    send(8'h03);
    send(8'hC1);
    send(8'h34);
    send(8'h12);
    drain();

    // illegal: mod 10 with ext=0
    sb.push_back(mk(1'b0, 7'd1, 2'b10, 3'd1, 3'd0,
                    16'h0, 3'd2, 1'b1));
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h01);
    send(8'h88);
    send(8'h00);
    drain();

    // illegal: opcode above max
    sb.push_back(mk(1'b0, 7'd7, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd2, 1'b1));
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h07);
    send(8'h00);
    send(8'h00);
    drain();

    // illegal: NOT with immediate
    sb.push_back(mk(1'b0, 7'd6, 2'b01, 3'd0, 3'd0,
                    16'h0, 3'd2, 1'b1));
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h06);
    send(8'h40);
    send(8'h00);
    drain();

    // backpressure: SUB R2,imm8
    out_ready = 1'b0;
    e_sub = mk(1'b0, 7'd2, 2'b01, 3'd2, 3'd0,
               16'h009B, 3'd3, 1'b0);
    sb.push_back(e_sub);
    send(8'h02);
    send(8'h50);
    send(8'h9B);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_bit("bp_valid", out_valid, 1'b1);
      chk_bit("bp_in_ready", in_ready, 1'b0);
      chk_dec("bp_hold", get_obs(), e_sub);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_bit("bp_one_xfer", out_valid, 1'b0);
    chk_bit("bp_popped", sb.size() == 0, 1'b1);
    @(posedge clk);
    #1;

    // flush mid-instruction
    send(8'h83);
    send(8'hC8);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    @(negedge clk);
    chk_bit("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_bit("flush_no_out", out_valid, 1'b0);
    @(posedge clk);
    #1;
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h00);
    valid_next();
    drain();

    // async reset mid-instruction
    send(8'h81);
    send(8'h48);
    send(8'hEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    chk_dec("mid_rst_fields", get_obs(), '0);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk(1'b0, 7'd0, 2'b00, 3'd0, 3'd0,
                    16'h0, 3'd1, 1'b0));
    send(8'h00);
    valid_next();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
